// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults for the decode-stage operand read path.
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
  localparam int ZERO_IDX   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_WIDTH-1:0]  xlen_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: DEPTH:1 indexed select, write-first bypass, hardwired x0 and optional
// output register (RD_REG=1 captures on rd_en_i, otherwise purely combinational).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ZERO_REG0 = 1,
  parameter int RD_REG    = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rd_en_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic [WIDTH-1:0]             rd_data_o
);

  logic [WIDTH-1:0] eff;

  // Priority: hardwired zero beats bypass, bypass beats stored value.
  always_comb begin
    eff = regs_i[rd_addr_i];
    if (we_i && (wr_addr_i == rd_addr_i)) eff = wr_data_i;
    if ((ZERO_REG0 != 0) && (rd_addr_i == ADDR_W'(ZERO_IDX))) eff = '0;
  end

  if (RD_REG != 0) begin : g_reg
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;

    assign rd_d = rd_en_i ? eff : rd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rd_q <= '0;
      else       rd_q <= rd_d;
    end

    assign rd_data_o = rd_q;
  end else begin : g_comb
    logic unused_rd_en;
    assign unused_rd_en = rd_en_i;

    // Storage is already clear in reset, but the bypass path is not.
    assign rd_data_o = rst_i ? '0 : eff;

    if (ZERO_REG0 != 0) begin : g_zero_chk
      a_zero_reads_zero: assert property (@(posedge clk_i) disable iff (rst_i)
        (rd_addr_i == ADDR_W'(ZERO_IDX)) |-> (rd_data_o == '0));
    end
  end

endmodule

// File: rtl/regfile_nrd.sv
// Decode-stage integer register file: DEPTH x WIDTH storage, one synchronous write port,
// NUM_RD independent read ports (see regfile_rd_port for bypass and registered-read behaviour).
module regfile_nrd
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 1,
  parameter int RD_REG    = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*WIDTH-1:0]    rd_data
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_nrd: DEPTH must be a power of two and at least 2");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_nrd: NUM_RD must be in 1..4");
  end

  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic [DEPTH-1:0][WIDTH-1:0] regs_d;
  logic                        wr_ok;

  assign wr_ok = we && !((ZERO_REG0 != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .ZERO_REG0 (ZERO_REG0),
      .RD_REG    (RD_REG)
    ) u_port (
      .clk_i     (clk),
      .rst_i     (rst),
      .rd_en_i   (rd_en),
      .we_i      (we),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .regs_i    (regs_q),
      .rd_addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
      .rd_data_o (rd_data[p*WIDTH +: WIDTH])
    );
  end

endmodule
